// File: rtl/vending_txn_ctrl.sv
// Vending transaction controller: coin intake, purchase, inactivity timeout and greedy change return.
// Optional build macro VENDING_AUTO_RETURN_EN enables the timeout-driven change return.
module vending_txn_ctrl #(
  parameter int TOTAL_BITS = 31,
  parameter int WAIT_TIME  = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            i_coin,
  input  logic [3:0]            i_select,
  input  logic                  i_trigger_return,
  output logic [TOTAL_BITS-1:0] o_current_total,
  output logic [31:0]           o_wait_time,
  output logic [3:0]            o_available_item,
  output logic [3:0]            o_output_item,
  output logic [2:0]            o_return_coin,
  output logic                  o_busy
);

  // Two guard bits so total + coin never wraps before the overflow compare.
  localparam int SW = TOTAL_BITS + 2;
  typedef logic [SW-1:0] wide_t;
  localparam wide_t      MAX_TOTAL   = (wide_t'(1) << TOTAL_BITS) - wide_t'(1);
  localparam logic [31:0] WAIT_RELOAD = 32'(WAIT_TIME);

`ifdef VENDING_AUTO_RETURN_EN
  localparam bit AUTO_RETURN = 1'b1;
`else
  localparam bit AUTO_RETURN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RETURN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TOTAL_BITS-1:0] total_q, total_d;
  logic [31:0]           wait_q, wait_d;
  logic [3:0]            item_q, item_d;
  logic [2:0]            rcoin_q, rcoin_d;
  logic                  busy_q, busy_d;

  function automatic wide_t coin_val(input logic [2:0] c);
    if (c[0])      return wide_t'(100);
    else if (c[1]) return wide_t'(500);
    else if (c[2]) return wide_t'(1000);
    return '0;
  endfunction

  function automatic wide_t price_of(input logic [3:0] s);
    if (s[0])      return wide_t'(400);
    else if (s[1]) return wide_t'(500);
    else if (s[2]) return wide_t'(1000);
    else if (s[3]) return wide_t'(2000);
    return '0;
  endfunction

  wide_t      tot_w, coin_w, price_w, paid_w, sum_w, new_w, rem_w;
  logic [3:0] sel_oh;
  logic       buy, coin_ok, reload, timeout;

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    wait_d  = wait_q;
    item_d  = '0;
    rcoin_d = '0;
    rem_w   = '0;
    reload  = 1'b0;
    timeout = 1'b0;

    tot_w   = wide_t'(total_q);
    coin_w  = coin_val(i_coin);
    sel_oh  = i_select & (~i_select + 4'd1);
    price_w = price_of(sel_oh);
    // Purchases only happen in ACTIVE; affordability uses the pre-update total.
    buy     = (state_q == ACTIVE) && (sel_oh != 4'd0) && (tot_w >= price_w);
    paid_w  = buy ? price_w : '0;
    sum_w   = tot_w - paid_w + coin_w;
    coin_ok = (coin_w != '0) && (sum_w <= MAX_TOTAL);
    new_w   = coin_ok ? sum_w : (tot_w - paid_w);

    case (state_q)
      IDLE: begin
        if (coin_ok) begin
          total_d = new_w[TOTAL_BITS-1:0];
          wait_d  = WAIT_RELOAD;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        reload  = coin_ok || buy;
        total_d = new_w[TOTAL_BITS-1:0];
        item_d  = buy ? sel_oh : 4'd0;
        if (reload)              wait_d = WAIT_RELOAD;
        else if (wait_q != 32'd0) wait_d = wait_q - 32'd1;
        timeout = AUTO_RETURN && !reload && (wait_q == 32'd0) && (total_q != '0);
        if (new_w == '0) begin
          state_d = IDLE;
          wait_d  = WAIT_RELOAD;
        end else if (i_trigger_return || timeout) begin
          state_d = RETURN;
        end
      end
      RETURN: begin
        if (tot_w >= wide_t'(1000)) begin
          rcoin_d = 3'b100;
          rem_w   = tot_w - wide_t'(1000);
        end else if (tot_w >= wide_t'(500)) begin
          rcoin_d = 3'b010;
          rem_w   = tot_w - wide_t'(500);
        end else if (tot_w >= wide_t'(100)) begin
          rcoin_d = 3'b001;
          rem_w   = tot_w - wide_t'(100);
        end
        // A sub-100 residual has no coin to match, so it falls through as rem_w = 0.
        total_d = rem_w[TOTAL_BITS-1:0];
        if (rem_w == '0) begin
          state_d = IDLE;
          wait_d  = WAIT_RELOAD;
        end
      end
      default: begin
        state_d = IDLE;
        total_d = '0;
        wait_d  = WAIT_RELOAD;
      end
    endcase

    busy_d = (state_d == RETURN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      total_q <= '0;
      wait_q  <= WAIT_RELOAD;
      item_q  <= '0;
      rcoin_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      wait_q  <= wait_d;
      item_q  <= item_d;
      rcoin_q <= rcoin_d;
      busy_q  <= busy_d;
    end
  end

  assign o_current_total = total_q;
  assign o_wait_time     = wait_q;
  assign o_output_item   = item_q;
  assign o_return_coin   = rcoin_q;
  assign o_busy          = busy_q;

  assign o_available_item[0] = (tot_w >= wide_t'(400));
  assign o_available_item[1] = (tot_w >= wide_t'(500));
  assign o_available_item[2] = (tot_w >= wide_t'(1000));
  assign o_available_item[3] = (tot_w >= wide_t'(2000));

endmodule

// File: doc/vending_txn_ctrl.md
# vending_txn_ctrl

Transaction controller for the vending machine. It sequences one customer session end to end: coin acceptance, item purchase, inactivity timeout and greedy change return. It owns the registered current-total and wait-time state, and the datapath and display logic read that state from its outputs. The block replaces open-coded next-state logic with a single three-state FSM.

## Interface
- TOTAL_BITS, 31: width of the current-total register.
- WAIT_TIME, 100: inactivity timeout in cycles.
- Coin values are fixed at 100, 500 and 1000 (indices 0, 1, 2).
- Item prices are fixed at 400, 500, 1000 and 2000 (indices 0, 1, 2, 3).
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_coin  in  3  coin-inserted strobe, one-hot, sampled every cycle.
- i_select  in  4  item-select strobe, one-hot.
- i_trigger_return  in  1  customer return request.
- o_current_total  out  TOTAL_BITS  registered balance.
- o_wait_time  out  32  registered countdown.
- o_available_item  out  4  bit i = (o_current_total >= price[i]); combinational from the register.
- o_output_item  out  4  one-cycle dispense pulse, registered.
- o_return_coin  out  3  one-hot coin-eject pulse, registered, at most one coin per cycle.
- o_busy  out  1  high while the FSM is in RETURN.

## Operation
- States are IDLE, ACTIVE and RETURN.
- **Reset:** state=IDLE, total=0, wait_time=WAIT_TIME, and o_output_item, o_return_coin and o_busy are 0. A reset mid-RETURN abandons the remaining change; no coin pulse follows reset.
- **Multi-hot inputs:** only the lowest set bit of i_coin or i_select is honoured.
- **IDLE:**
  - A coin adds its value, reloads wait_time and moves to ACTIVE.
  - i_select is ignored.
  - i_trigger_return with total=0 is a no-op.
- **ACTIVE, every cycle:** wait_time decrements by 1, saturating at 0, unless it is reloaded that cycle.
- **ACTIVE, coin:** total += value and wait_time reloads to WAIT_TIME. The coin is rejected when the sum would exceed 2^TOTAL_BITS-1; a rejected coin causes no reload and no total change.
- **ACTIVE, select:**
  - Item i is dispensed if the pre-update total >= price[i]. Dispense sets the o_output_item[i] pulse, total -= price[i] and reloads wait_time.
  - An unaffordable select is ignored: no pulse, no reload.
- **Coin and select in the same cycle:**
  - Affordability is checked against the pre-update total.
  - total_nxt = total + coin - price, with overflow checked on the final value.
- **ACTIVE to RETURN:** on i_trigger_return, or on wait_time==0 with total>0. If return and select arrive in the same cycle, the purchase completes first and the next state is RETURN.
- **ACTIVE to IDLE:** when total==0 after an update, with wait_time reloaded to WAIT_TIME.
- **RETURN:**
  - Each cycle the block ejects the largest coin <= total on o_return_coin and subtracts its value.
  - i_coin, i_select and i_trigger_return are ignored; upstream must not drop coins while o_busy is high.
  - When total reaches 0 the FSM enters IDLE and wait_time reloads.
  - A residual below 100 cannot be returned: it is discarded and the FSM goes to IDLE with total=0.

## Timing
- Inputs are sampled at edge N; o_current_total, o_wait_time, o_output_item and o_return_coin reflect the result after edge N.
- Dispense latency: 1 cycle from the select strobe.
- The first change coin appears on the edge that enters RETURN plus 1 cycle.
- The number of return cycles equals the greedy coin count.
- o_busy rises with entry to RETURN and falls in the cycle the state becomes IDLE.
- The timeout fires on the edge where o_wait_time==0 is sampled, i.e. WAIT_TIME+1 cycles after the last reload with no activity.

## Configuration
- **VENDING_AUTO_RETURN_EN defined:** timeout (wait_time==0, total>0) forces RETURN as described above.
- **VENDING_AUTO_RETURN_EN undefined:** wait_time still counts down and saturates at 0, but RETURN is entered only on i_trigger_return; the balance is held indefinitely.

## Test plan
- Reset, then insert 1000 and 500 on consecutive cycles -> total=1500 and o_available_item=4'b0111. Select item 2 -> o_output_item=4'b0100 one cycle later and total=500.
- Total=300, select item 0 (price 400) -> no pulse, total stays 300, wait_time keeps decrementing.
- Total=1600, assert i_trigger_return -> o_return_coin pulses 1000, 500, 100 on consecutive cycles; o_busy high for 3 cycles; then IDLE with total=0.
- WAIT_TIME=10, insert 500, then idle:
  - With VENDING_AUTO_RETURN_EN defined -> RETURN is entered 11 cycles after the coin and one 500 coin is ejected.
  - Without the macro -> total=500 is held for 50 cycles with wait_time=0.
- Total=400, same-cycle coin 100 and select item 0 -> pulse on item 0 and total=100.
- Mid-RETURN (total=1500 after the first eject), assert reset -> the next cycle shows o_return_coin=0, total=0 and IDLE.
